// File: rtl/game_pkg.sv
// Shared constants and state encoding for the alien formation logic.
// Latency: n/a; no backpressure.
package game_pkg;

    localparam int COLS       = 5;
    localparam int ROWS       = 2;
    localparam int NUM_ALIENS = COLS * ROWS;
    localparam int SPRITE_W   = 50;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PARK_Y     = 480;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DECIDE,
        ST_CLEAR,
        ST_INVADED
    } state_t;

endpackage

// File: rtl/formation_extent.sv
// Alive mask -> leftmost/rightmost occupied column and lowest occupied row.
// Latency: combinational; no backpressure.
module formation_extent
    import game_pkg::*;
(
    input  logic [NUM_ALIENS-1:0] i_alive,
    output logic [COL_W-1:0]      o_mincol,
    output logic [COL_W-1:0]      o_maxcol,
    output logic [ROW_W-1:0]      o_maxrow,
    output logic                  o_any_alive
);

    logic [COLS-1:0] w_col_any;
    logic [ROWS-1:0] w_row_any;

    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_alive[r*COLS + c]) begin
                    w_col_any[c] = 1'b1;
                    w_row_any[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_mincol = '0;
        o_maxcol = '0;
        o_maxrow = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (w_col_any[c]) o_mincol = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_col_any[c]) o_maxcol = COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (w_row_any[r]) o_maxrow = ROW_W'(r);
        end
    end

    assign o_any_alive = |i_alive;

endmodule

// File: rtl/alien_formation_mover.sv
// Marches the alien formation, bounces it at screen edges, tracks kills and end-of-wave flags.
// Latency: coordinates update 2 edges after the qualifying frame_tick; no backpressure.
module alien_formation_mover
    import game_pkg::*;
#(
    parameter int X_SPACING       = 60,
    parameter int Y_SPACING       = 60,
    parameter int START_X         = 40,
    parameter int START_Y         = 40,
    parameter int STEP_X          = 2,
    parameter int STEP_DOWN       = 20,
    parameter int FRAMES_PER_STEP = 4,
    parameter int INVADE_Y        = 380
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        start,
    input  logic                        kill_valid,
    input  logic [3:0]                  kill_idx,
    output logic [NUM_ALIENS*X_W-1:0]   alien_x,
    output logic [NUM_ALIENS*Y_W-1:0]   alien_y,
    output logic [NUM_ALIENS-1:0]       alive,
    output logic                        running,
    output logic                        wave_clear,
    output logic                        invaded
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    function automatic logic [NUM_ALIENS*X_W-1:0] f_pack_x(input logic [X_W-1:0] ox);
        logic [NUM_ALIENS*X_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            v[i*X_W +: X_W] = ox + X_W'((i % COLS) * X_SPACING);
        end
        return v;
    endfunction

    function automatic logic [NUM_ALIENS*Y_W-1:0] f_pack_y(input logic [Y_W-1:0] oy,
                                                          input logic [NUM_ALIENS-1:0] mask);
        logic [NUM_ALIENS*Y_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_ALIENS; i++) begin
            v[i*Y_W +: Y_W] = mask[i] ? (oy + Y_W'((i / COLS) * Y_SPACING)) : Y_W'(PARK_Y);
        end
        return v;
    endfunction

    state_t                    r_state, w_state_nxt;
    logic [X_W-1:0]            r_origin_x, w_origin_x_nxt;
    logic [Y_W-1:0]            r_origin_y, w_origin_y_nxt;
    logic                      r_dir_left, w_dir_left_nxt;
    logic [FC_W-1:0]           r_frame_cnt, w_frame_cnt_nxt;
    logic [NUM_ALIENS-1:0]     r_alive, w_alive_nxt, w_alive_killed;
    logic                      r_wave_clear, w_wave_clear_nxt;
    logic                      r_invaded, w_invaded_nxt;
    logic                      r_running;
    logic [NUM_ALIENS*X_W-1:0] r_alien_x;
    logic [NUM_ALIENS*Y_W-1:0] r_alien_y;

    logic [COL_W-1:0]          w_mincol, w_maxcol;
    logic [ROW_W-1:0]          w_maxrow;
    logic                      w_any_alive;
    logic                      w_kill_hit;
    logic [11:0]               w_right_edge, w_left_edge;
    logic [10:0]               w_bottom;
    logic                      w_bounce;
    logic [X_W-1:0]            w_moved_x;
    logic [Y_W-1:0]            w_moved_y;

    // Extents come from the registered mask, so a same-cycle kill does not affect DECIDE.
    formation_extent u_extent (
        .i_alive     (r_alive),
        .o_mincol    (w_mincol),
        .o_maxcol    (w_maxcol),
        .o_maxrow    (w_maxrow),
        .o_any_alive (w_any_alive)
    );

    assign w_kill_hit     = kill_valid && (r_state != ST_IDLE) && (kill_idx < 4'(NUM_ALIENS));
    assign w_alive_killed = w_kill_hit ? (r_alive & ~(NUM_ALIENS'(1) << kill_idx)) : r_alive;

    assign w_right_edge = 12'(r_origin_x) + 12'(w_maxcol) * 12'(X_SPACING) + 12'(SPRITE_W + STEP_X);
    assign w_left_edge  = 12'(r_origin_x) + 12'(w_mincol) * 12'(X_SPACING);
    assign w_bounce     = w_any_alive && (r_dir_left ? (w_left_edge < 12'(STEP_X))
                                                     : (w_right_edge > 12'(SCREEN_W)));

    assign w_moved_x = w_bounce   ? r_origin_x :
                       r_dir_left ? (r_origin_x - X_W'(STEP_X)) : (r_origin_x + X_W'(STEP_X));
    assign w_moved_y = w_bounce ? (r_origin_y + Y_W'(STEP_DOWN)) : r_origin_y;
    assign w_bottom  = 11'(w_moved_y) + 11'(w_maxrow) * 11'(Y_SPACING) + 11'(SPRITE_W);

    always_comb begin
        w_state_nxt      = r_state;
        w_origin_x_nxt   = r_origin_x;
        w_origin_y_nxt   = r_origin_y;
        w_dir_left_nxt   = r_dir_left;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_alive_nxt      = w_alive_killed;
        w_wave_clear_nxt = r_wave_clear;
        w_invaded_nxt    = r_invaded;

        case (r_state)
            ST_IDLE, ST_CLEAR, ST_INVADED: begin
                if (start) begin
                    w_state_nxt      = ST_RUN;
                    w_origin_x_nxt   = X_W'(START_X);
                    w_origin_y_nxt   = Y_W'(START_Y);
                    w_dir_left_nxt   = 1'b0;
                    w_frame_cnt_nxt  = '0;
                    w_alive_nxt      = '1;
                    w_wave_clear_nxt = 1'b0;
                    w_invaded_nxt    = 1'b0;
                end
            end
            ST_RUN: begin
                if (frame_tick) begin
                    if (r_frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
                        w_frame_cnt_nxt = '0;
                        w_state_nxt     = ST_DECIDE;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            ST_DECIDE: begin
                w_origin_x_nxt = w_moved_x;
                w_origin_y_nxt = w_moved_y;
                w_dir_left_nxt = r_dir_left ^ w_bounce;
                if (w_bottom >= 11'(INVADE_Y)) begin
                    w_state_nxt   = ST_INVADED;
                    w_invaded_nxt = 1'b1;
                end else begin
                    w_state_nxt   = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Losing the last alien wins over an invade decision in the same cycle.
        if ((r_state == ST_RUN || r_state == ST_DECIDE) && (w_alive_killed == '0)) begin
            w_state_nxt      = ST_CLEAR;
            w_wave_clear_nxt = 1'b1;
            w_invaded_nxt    = r_invaded;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_origin_x   <= X_W'(START_X);
            r_origin_y   <= Y_W'(START_Y);
            r_dir_left   <= 1'b0;
            r_frame_cnt  <= '0;
            r_alive      <= '0;
            r_wave_clear <= 1'b0;
            r_invaded    <= 1'b0;
            r_running    <= 1'b0;
            r_alien_x    <= f_pack_x(X_W'(START_X));
            r_alien_y    <= f_pack_y(Y_W'(START_Y), '0);
        end else begin
            r_state      <= w_state_nxt;
            r_origin_x   <= w_origin_x_nxt;
            r_origin_y   <= w_origin_y_nxt;
            r_dir_left   <= w_dir_left_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_alive      <= w_alive_nxt;
            r_wave_clear <= w_wave_clear_nxt;
            r_invaded    <= w_invaded_nxt;
            r_running    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DECIDE);
            r_alien_x    <= f_pack_x(w_origin_x_nxt);
            r_alien_y    <= f_pack_y(w_origin_y_nxt, w_alive_nxt);
        end
    end

    assign alien_x    = r_alien_x;
    assign alien_y    = r_alien_y;
    assign alive      = r_alive;
    assign running    = r_running;
    assign wave_clear = r_wave_clear;
    assign invaded    = r_invaded;

endmodule

// File: tb/tb_alien_formation_mover.sv
// Self-checking bench: vector table, directed march/bounce/kill/invade sequences, random stimulus vs model.
module tb_alien_formation_mover;

    localparam int FPS = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_DEC = 2, M_CLEAR = 3, M_INV = 4;

    logic         clk;
    logic         reset;
    logic         frame_tick;
    logic         start;
    logic         kill_valid;
    logic [3:0]   kill_idx;
    logic [99:0]  alien_x;
    logic [89:0]  alien_y;
    logic [9:0]   alive;
    logic         running;
    logic         wave_clear;
    logic         invaded;

    int n_vec = 0;
    int n_err = 0;

    int       m_mode, m_ox, m_oy, m_fc;
    bit       m_right, m_clr, m_inv;
    bit [9:0] m_alive;

    alien_formation_mover #(.FRAMES_PER_STEP(FPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .kill_valid (kill_valid),
        .kill_idx   (kill_idx),
        .alien_x    (alien_x),
        .alien_y    (alien_y),
        .alive      (alive),
        .running    (running),
        .wave_clear (wave_clear),
        .invaded    (invaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = M_IDLE; m_ox = 40; m_oy = 40; m_fc = 0;
        m_right = 1; m_clr = 0; m_inv = 0; m_alive = '0;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit kv, input int ki);
        int       nmode, nox, noy, nfc, minc, maxc, maxr;
        bit       nright, nclr, ninv, bounce;
        bit [9:0] na;
        nmode = m_mode; nox = m_ox; noy = m_oy; nfc = m_fc;
        nright = m_right; nclr = m_clr; ninv = m_inv; na = m_alive;
        if (st && (m_mode == M_IDLE || m_mode == M_CLEAR || m_mode == M_INV)) begin
            nmode = M_RUN; na = '1; nox = 40; noy = 40; nright = 1; nfc = 0; nclr = 0; ninv = 0;
        end else begin
            if (kv && m_mode != M_IDLE && ki < 10) na[ki] = 1'b0;
            if (m_mode == M_RUN && tk) begin
                if (m_fc == FPS - 1) begin nfc = 0; nmode = M_DEC; end
                else nfc = m_fc + 1;
            end
            if (m_mode == M_DEC) begin
                minc = 99; maxc = -1; maxr = -1;
                for (int i = 0; i < 10; i++) begin
                    if (m_alive[i]) begin
                        if (i % 5 < minc) minc = i % 5;
                        if (i % 5 > maxc) maxc = i % 5;
                        if (i / 5 > maxr) maxr = i / 5;
                    end
                end
                if (m_right) bounce = (m_ox + maxc * 60 + 50 + 2) > 640;
                else         bounce = (m_ox + minc * 60) < 2;
                if (bounce) begin noy = m_oy + 20; nright = !m_right; end
                else nox = m_right ? m_ox + 2 : m_ox - 2;
                if (noy + maxr * 60 + 50 >= 380) begin nmode = M_INV; ninv = 1; end
                else nmode = M_RUN;
            end
            if ((m_mode == M_RUN || m_mode == M_DEC) && na == 0) begin
                nmode = M_CLEAR; nclr = 1; ninv = m_inv;
            end
        end
        m_mode = nmode; m_ox = nox; m_oy = noy; m_fc = nfc;
        m_right = nright; m_clr = nclr; m_inv = ninv; m_alive = na;
    endtask

    task automatic check_all(input string name);
        logic [99:0] ex;
        logic [89:0] ey;
        bit          er;
        for (int i = 0; i < 10; i++) begin
            ex[i*10 +: 10] = 10'(m_ox + (i % 5) * 60);
            ey[i*9 +: 9]   = m_alive[i] ? 9'(m_oy + (i / 5) * 60) : 9'd480;
        end
        er = (m_mode == M_RUN || m_mode == M_DEC);
        n_vec++;
        if (alien_x !== ex || alien_y !== ey || alive !== m_alive || running !== er ||
            wave_clear !== m_clr || invaded !== m_inv) begin
            n_err++;
            $display("FAIL %s t=%0t: x=%h/%h y=%h/%h alive=%h/%h run=%b/%b clr=%b/%b inv=%b/%b (got/want)",
                     name, $time, alien_x, ex, alien_y, ey, alive, m_alive, running, er,
                     wave_clear, m_clr, invaded, m_inv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit tk, input bit kv, input int ki);
        start = st; frame_tick = tk; kill_valid = kv; kill_idx = 4'(ki);
        @(posedge clk);
        model_step(st, tk, kv, ki);
        #1;
        check_all("cycle");
        @(negedge clk);
        start = 0; frame_tick = 0; kill_valid = 0; kill_idx = 0;
    endtask

    task automatic march_step();
        for (int k = 0; k < FPS; k++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit       st;
        bit       tk;
        bit       kv;
        int       ki;
        int       x0;
        int       y4;
        bit [9:0] al;
        bit       run;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 0, 0,  40,  40, 10'h3FF, 1};
        tbl[1]  = '{0, 1, 0, 0,  40,  40, 10'h3FF, 1};
        tbl[2]  = '{0, 0, 0, 0,  40,  40, 10'h3FF, 1};
        tbl[3]  = '{0, 1, 0, 0,  40,  40, 10'h3FF, 1};
        tbl[4]  = '{0, 1, 0, 0,  40,  40, 10'h3FF, 1};
        tbl[5]  = '{0, 1, 0, 0,  42,  40, 10'h3FF, 1};
        tbl[6]  = '{1, 0, 0, 0,  42,  40, 10'h3FF, 1};
        tbl[7]  = '{0, 1, 0, 0,  42,  40, 10'h3FF, 1};
        tbl[8]  = '{0, 0, 1, 4,  42, 480, 10'h3EF, 1};
        tbl[9]  = '{0, 0, 1, 12, 42, 480, 10'h3EF, 1};
        tbl[10] = '{0, 1, 0, 0,  42, 480, 10'h3EF, 1};
        tbl[11] = '{0, 1, 0, 0,  42, 480, 10'h3EF, 1};
        tbl[12] = '{0, 0, 0, 0,  44, 480, 10'h3EF, 1};
        tbl[13] = '{0, 0, 1, 4,  44, 480, 10'h3EF, 1};

        reset = 1'b0; start = 0; frame_tick = 0; kill_valid = 0; kill_idx = 0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset_state");
        check_int("reset_alien5_x", int'(alien_x[59:50]), 40);
        #2 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].st, tbl[i].tk, tbl[i].kv, tbl[i].ki);
            check_int($sformatf("tbl%0d_x0", i), int'(alien_x[9:0]), tbl[i].x0);
            check_int($sformatf("tbl%0d_y4", i), int'(alien_y[44:36]), tbl[i].y4);
            check_int($sformatf("tbl%0d_alive", i), int'(alive), int'(tbl[i].al));
            check_int($sformatf("tbl%0d_run", i), int'(running), int'(tbl[i].run));
        end

        // Full-formation march to the right edge and bounce.
        async_reset();
        cyc(1, 0, 0, 0);
        check_int("start_x4", int'(alien_x[49:40]), 280);
        check_int("start_y5", int'(alien_y[53:45]), 100);
        for (int s = 0; s < 155; s++) march_step();
        check_int("march_x0", int'(alien_x[9:0]), 350);
        march_step();
        check_int("bounce_x0", int'(alien_x[9:0]), 350);
        check_int("bounce_y0", int'(alien_y[8:0]), 60);
        march_step();
        check_int("left_x0", int'(alien_x[9:0]), 348);

        // Column 4 dead: right edge moves out by one column pitch.
        async_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 4);
        cyc(0, 0, 1, 9);
        for (int s = 0; s < 185; s++) march_step();
        check_int("col3_x0", int'(alien_x[9:0]), 410);
        check_int("col3_y0", int'(alien_y[8:0]), 40);
        march_step();
        check_int("col3_bounce_x0", int'(alien_x[9:0]), 410);
        check_int("col3_bounce_y0", int'(alien_y[8:0]), 60);
        check_int("col3_y4_parked", int'(alien_y[44:36]), 480);

        // Kill all, with a duplicate and an out-of-range index.
        async_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 12);
        for (int k = 2; k < 9; k++) cyc(0, 1, 1, k);
        check_int("clear_before_last", int'(wave_clear), 0);
        cyc(0, 0, 1, 9);
        check_int("clear_flag", int'(wave_clear), 1);
        check_int("clear_running", int'(running), 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check_int("restart_from_clear", int'(alive), 10'h3FF);

        // Row 1 dead: march to the bottom.
        async_reset();
        cyc(1, 0, 0, 0);
        for (int k = 5; k < 10; k++) cyc(0, 0, 1, k);
        for (int s = 0; s < 5000 && !invaded; s++) march_step();
        check_int("invaded_flag", int'(invaded), 1);
        check_int("invaded_y0", int'(alien_y[8:0]), 340);
        check_int("invaded_running", int'(running), 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        check_int("restart_x0", int'(alien_x[9:0]), 40);
        check_int("restart_y0", int'(alien_y[8:0]), 40);
        check_int("restart_alive", int'(alive), 10'h3FF);
        check_int("restart_invaded", int'(invaded), 0);

        // Reset asserted while in DECIDE.
        for (int k = 0; k < FPS; k++) cyc(0, 1, 0, 0);
        async_reset();
        check_int("rst_dec_running", int'(running), 0);
        check_int("rst_dec_alive", int'(alive), 0);

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            bit st, tk, kv;
            st = ($urandom_range(0, 99) < ((m_mode == M_RUN || m_mode == M_DEC) ? 3 : 30));
            tk = $urandom_range(0, 1) == 1;
            kv = $urandom_range(0, 99) < 4;
            cyc(st, tk, kv, int'($urandom_range(0, 15)));
            if (n == 2000) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
